// File: rtl/cfg_sequencer.sv
// Si5340 configuration-load sequencer: walks the config ROM and emits I2C page/register writes byte by byte.
// Optional page-register caching is enabled by defining CFG_PAGE_CACHE_EN.
module cfg_sequencer #(
    parameter int unsigned MEM_DEPTH    = 326,
    parameter int unsigned MEM_WIDTH    = 24,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [6:0]  SLAVE_ADDR   = 7'b111_0100,
    parameter int unsigned PREAMBLE_LEN = 3,
    parameter int unsigned DELAY_CYCLES = 37_500_000
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         start_i,
    output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
    input  logic [MEM_WIDTH-1:0]         rom_data_i,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic [DATA_WIDTH-1:0]        tx_data_o,
    output logic                         tx_start_o,
    output logic                         tx_stop_o,
    input  logic                         tx_done_i,
    input  logic                         tx_nack_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [$clog2(MEM_DEPTH)-1:0] rec_idx_o
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = $clog2(DELAY_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] ADDR_BYTE = DATA_WIDTH'({SLAVE_ADDR, 1'b0});
    localparam logic [DATA_WIDTH-1:0] PAGE_SEL  = DATA_WIDTH'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);
    localparam logic [AW-1:0] LAST_PRE = AW'(PREAMBLE_LEN - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, WAIT, DELAY, NEXT, DONE} state_t;

    state_t                 state;
    logic [AW-1:0]          idx;
    logic [2:0]             ptr;
    logic [2:0]             first_ptr;
    logic [DATA_WIDTH-1:0]  rec_page, rec_reg, rec_data;
    logic [DATA_WIDTH-1:0]  in_page, in_reg, in_data;
    logic [CW-1:0]          cnt;
    logic                   skip_page;
`ifdef CFG_PAGE_CACHE_EN
    logic [DATA_WIDTH-1:0]  cache_page;
    logic                   cache_valid;
`endif

    assign in_page = rom_data_i[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign in_reg  = rom_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign in_data = rom_data_i[DATA_WIDTH-1:0];

    assign rom_addr_o = idx;
    assign rec_idx_o  = idx;

    always_comb begin
`ifdef CFG_PAGE_CACHE_EN
        skip_page = cache_valid && (in_page == cache_page);
`else
        skip_page = 1'b0;
`endif
        first_ptr = skip_page ? 3'd3 : 3'd0;
    end

    // Pointers 0..2 are the page-select write, 3..5 the register write; result is {start, stop, byte}.
    function automatic logic [DATA_WIDTH+1:0] encode(input logic [2:0] p,
                                                     input logic [DATA_WIDTH-1:0] pg,
                                                     input logic [DATA_WIDTH-1:0] rg,
                                                     input logic [DATA_WIDTH-1:0] dt);
        case (p)
            3'd0, 3'd3: encode = {1'b1, 1'b0, ADDR_BYTE};
            3'd1:       encode = {1'b0, 1'b0, PAGE_SEL};
            3'd2:       encode = {1'b0, 1'b1, pg};
            3'd4:       encode = {1'b0, 1'b0, rg};
            default:    encode = {1'b0, 1'b1, dt};
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            idx        <= '0;
            ptr        <= '0;
            rec_page   <= '0;
            rec_reg    <= '0;
            rec_data   <= '0;
            cnt        <= '0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            tx_start_o <= 1'b0;
            tx_stop_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
`ifdef CFG_PAGE_CACHE_EN
            cache_page  <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    error_o <= 1'b0;
                    idx     <= '0;
                    busy_o  <= 1'b1;
`ifdef CFG_PAGE_CACHE_EN
                    cache_valid <= 1'b0;
`endif
                    state   <= FETCH;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    rec_page   <= in_page;
                    rec_reg    <= in_reg;
                    rec_data   <= in_data;
                    ptr        <= first_ptr;
                    {tx_start_o, tx_stop_o, tx_data_o} <= encode(first_ptr, in_page, in_reg, in_data);
                    tx_valid_o <= 1'b1;
`ifdef CFG_PAGE_CACHE_EN
                    cache_valid <= 1'b1;
                    cache_page  <= in_page;
`endif
                    state      <= SEND;
                end
                SEND: if (tx_ready_i) begin
                    tx_valid_o <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: if (tx_done_i) begin
                    if (tx_nack_i) begin
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end else if (ptr == 3'd5) begin
                        if (idx == LAST_PRE) begin
                            cnt   <= CW'(DELAY_CYCLES - 1);
                            state <= DELAY;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        ptr        <= ptr + 3'd1;
                        {tx_start_o, tx_stop_o, tx_data_o} <= encode(ptr + 3'd1, rec_page, rec_reg, rec_data);
                        tx_valid_o <= 1'b1;
                        state      <= SEND;
                    end
                end
                DELAY: begin
                    if (cnt == '0) state <= NEXT;
                    else           cnt   <= cnt - 1'b1;
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer: 4-record ROM, short settle delay, byte-engine model with stall/NACK injection.
module tb_cfg_sequencer;

`ifdef CFG_PAGE_CACHE_EN
    localparam int NB       = 18;
    localparam int DB       = 15;
    localparam int NACK_IDX = 10;
    logic [7:0] exp_bytes [NB] = '{8'hE8, 8'h01, 8'h00, 8'hE8, 8'h0B, 8'h68,
                                   8'hE8, 8'h0C, 8'h01,
                                   8'hE8, 8'h01, 8'h05, 8'hE8, 8'h02, 8'hAA,
                                   8'hE8, 8'h03, 8'hBB};
`else
    localparam int NB       = 24;
    localparam int DB       = 18;
    localparam int NACK_IDX = 13;
    logic [7:0] exp_bytes [NB] = '{8'hE8, 8'h01, 8'h00, 8'hE8, 8'h0B, 8'h68,
                                   8'hE8, 8'h01, 8'h00, 8'hE8, 8'h0C, 8'h01,
                                   8'hE8, 8'h01, 8'h05, 8'hE8, 8'h02, 8'hAA,
                                   8'hE8, 8'h01, 8'h05, 8'hE8, 8'h03, 8'hBB};
`endif

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  rom_addr_o;
    logic [23:0] rom_data_i = '0;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic [7:0]  tx_data_o;
    logic        tx_start_o, tx_stop_o;
    logic        tx_done_i = 1'b0;
    logic        tx_nack_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [1:0]  rec_idx_o;

    cfg_sequencer #(
        .MEM_DEPTH(4),
        .PREAMBLE_LEN(3),
        .DELAY_CYCLES(10)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .tx_start_o(tx_start_o), .tx_stop_o(tx_stop_o),
        .tx_done_i(tx_done_i), .tx_nack_i(tx_nack_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .rec_idx_o(rec_idx_o)
    );

    always #5 clk_i = ~clk_i;

    logic [23:0] rom [4] = '{24'h000B68, 24'h000C01, 24'h0502AA, 24'h0503BB};
    always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk_i) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-engine model: records each handshake as {start, stop, byte}, answers with tx_done two cycles later.
    logic [9:0] cap_q [$];
    int         cyc_q [$];
    int         nack_at  = -1;
    int         stall_at = -1;
    int         stall_cnt = 0;
    int         wcnt = 0;
    bit         pend = 1'b0;
    logic [9:0] held = '0;
    logic [9:0] cur;

    always @(negedge clk_i) begin
        tx_done_i = 1'b0;
        tx_nack_i = 1'b0;
        if (arst_i) begin
            pend       = 1'b0;
            tx_ready_i = 1'b1;
        end else if (pend) begin
            chk("valid_in_wait", tx_valid_o, 1'b0);
            if (wcnt == 0) begin
                tx_done_i = 1'b1;
                tx_nack_i = (cap_q.size() - 1 == nack_at);
                pend      = 1'b0;
            end else begin
                wcnt--;
            end
        end else if (tx_valid_o) begin
            cur = {tx_start_o, tx_stop_o, tx_data_o};
            if (cap_q.size() == stall_at && stall_cnt < 5) begin
                if (stall_cnt > 0) chk("stall_hold", cur, held);
                else               held = cur;
                tx_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                if (cap_q.size() == stall_at) chk("stall_release", cur, held);
                tx_ready_i = 1'b1;
                cap_q.push_back(cur);
                cyc_q.push_back(cyc);
                pend = 1'b1;
                wcnt = 1;
            end
        end
    end

    int done_cnt = 0;
    always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"}, tx_valid_o, 0);
        chk({pfx, "_data"},  tx_data_o, 0);
        chk({pfx, "_start"}, tx_start_o, 0);
        chk({pfx, "_stop"},  tx_stop_o, 0);
        chk({pfx, "_busy"},  busy_o, 0);
        chk({pfx, "_done"},  done_o, 0);
        chk({pfx, "_error"}, error_o, 0);
        chk({pfx, "_addr"},  rom_addr_o, 0);
        chk({pfx, "_idx"},   rec_idx_o, 0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int n = 0;
        while (done_o !== 1'b1 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_done_seen"}, done_o, 1'b1);
    endtask

    task automatic check_stream(input string tag, input int base);
        int gap;
        chk({tag, "_nbytes"}, cap_q.size() - base, NB);
        for (int i = 0; i < NB && base + i < cap_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), cap_q[base + i],
                {(i % 3 == 0), (i % 3 == 2), exp_bytes[i]});
        if (cap_q.size() >= base + NB) begin
            gap = cyc_q[base + DB] - cyc_q[base + DB - 1];
            chk({tag, "_delay_gap"}, (gap >= 10), 1'b1);
        end
    endtask

    initial begin
        int base, d0, n;
        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        arst_i = 1'b0;
        n = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (tx_valid_o) n++;
        end
        chk("idle_valid_count", n, 0);
        chk("idle_busy", busy_o, 0);

        // Full load with a 5-cycle ready stall on the fifth byte.
        base = cap_q.size();
        d0 = done_cnt;
        stall_at = base + 4;
        pulse_start();
        chk("fetch_busy", busy_o, 1);
        chk("fetch_addr", rom_addr_o, 0);
        chk("fetch_valid", tx_valid_o, 0);
        @(negedge clk_i);
        chk("latch_valid", tx_valid_o, 0);
        @(negedge clk_i);
        chk("send_valid", tx_valid_o, 1);
        chk("send_byte", {tx_start_o, tx_stop_o, tx_data_o}, {1'b1, 1'b0, 8'hE8});
        run_to_done("run1");
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("after_done_busy", busy_o, 0);
        @(negedge clk_i);
        chk("ignored_start_busy", busy_o, 0);
        chk("ignored_start_valid", tx_valid_o, 0);
        chk("run1_done_pulses", done_cnt - d0, 1);
        chk("run1_error", error_o, 0);
        chk("run1_stall_cycles", stall_cnt, 5);
        check_stream("run1", base);
        stall_at = -1;

        // NACK on the second byte of record 2.
        base = cap_q.size();
        d0 = done_cnt;
        nack_at = base + NACK_IDX;
        pulse_start();
        n = 0;
        while (busy_o === 1'b1 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk("nack_busy_drop", busy_o, 0);
        chk("nack_error", error_o, 1);
        chk("nack_rec_idx", rec_idx_o, 2);
        repeat (5) @(negedge clk_i);
        chk("nack_error_sticky", error_o, 1);
        chk("nack_valid", tx_valid_o, 0);
        chk("nack_nbytes", cap_q.size() - base, NACK_IDX + 1);
        chk("nack_no_done", done_cnt - d0, 0);
        nack_at = -1;

        // Restart after NACK clears the error and begins at record 0.
        base = cap_q.size();
        d0 = done_cnt;
        pulse_start();
        chk("restart_error_clr", error_o, 0);
        chk("restart_idx", rec_idx_o, 0);
        run_to_done("run2");
        @(negedge clk_i);
        chk("run2_done_pulses", done_cnt - d0, 1);
        check_stream("run2", base);

        // Asynchronous reset during the settle delay.
        base = cap_q.size();
        pulse_start();
        n = 0;
        while (cap_q.size() < base + DB && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk("delay_reached", cap_q.size() - base, DB);
        repeat (6) @(negedge clk_i);
        chk("in_delay_busy", busy_o, 1);
        chk("in_delay_valid", tx_valid_o, 0);
        arst_i = 1'b1;
        @(negedge clk_i);
        chk_zero("arst");
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        base = cap_q.size();
        d0 = done_cnt;
        pulse_start();
        run_to_done("run3");
        @(negedge clk_i);
        chk("run3_done_pulses", done_cnt - d0, 1);
        check_stream("run3", base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
